// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with optional packet lock: grants one requester per cycle
// combinationally and rotates priority after each completed grant.
module rr_lock_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter bit LOCK_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQS-1:0] req,
  input  logic                ready,
  // Packet-tail marker; "release" is a reserved word, hence the prefix.
  input  logic                pkt_release,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid,
  output logic                locked
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [IDX_W-1:0]   lock_idx;
  logic [IDX_W-1:0]   lock_idx_nxt;

  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   rr_cand;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic               transfer;

  // Successor index with wrap, so the pointer never leaves 0..NUM_REQS-1.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (int'(v) >= NUM_REQS - 1) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // Scan requesters starting at ptr and wrapping; the first hit wins.
  always_comb begin
    int j;
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    j        = 0;
    for (int i = 0; i < NUM_REQS; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQS) begin
        j = j - NUM_REQS;
      end
      rr_cand = IDX_W'(j);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_idx_nxt = lock_idx;
    sel_valid    = 1'b0;
    sel_idx      = '0;

    case (state)
      IDLE: begin
        sel_valid = rr_found;
        sel_idx   = rr_idx;
      end
      LOCKED: begin
        // Only the lock owner may be granted; anyone else waits for the tail.
        sel_valid = req[lock_idx];
        sel_idx   = req[lock_idx] ? lock_idx : '0;
      end
      default: begin
        sel_valid = 1'b0;
        sel_idx   = '0;
      end
    endcase

    transfer = sel_valid & ready;

    case (state)
      IDLE: begin
        if (transfer) begin
          if (pkt_release || !LOCK_EN) begin
            ptr_nxt = wrap_inc(sel_idx);
          end else begin
            state_nxt    = LOCKED;
            lock_idx_nxt = sel_idx;
          end
        end
      end
      LOCKED: begin
        if (transfer && pkt_release) begin
          state_nxt = IDLE;
          ptr_nxt   = wrap_inc(lock_idx);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held, even with requests present.
    grant_valid = reset_n & sel_valid;
    grant_idx   = grant_valid ? sel_idx : '0;
    locked      = reset_n & (state == LOCKED);
    for (int i = 0; i < NUM_REQS; i++) begin
      grant[i] = grant_valid && (sel_idx == IDX_W'(i));
    end
  end

endmodule
